// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared encodings for the X/Y/Z + ULA sequencer: opcodes,
//            register control codes, ULA operations and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Instruction opcodes (upper three bits of the program word)
  localparam logic [2:0] C_OP_LDX  = 3'b000;
  localparam logic [2:0] C_OP_ADD  = 3'b001;
  localparam logic [2:0] C_OP_SUB  = 3'b010;
  localparam logic [2:0] C_OP_CLR  = 3'b011;
  localparam logic [2:0] C_OP_MOVZ = 3'b100;
  localparam logic [2:0] C_OP_SHR  = 3'b101;
  localparam logic [2:0] C_OP_JNZ  = 3'b110;
  localparam logic [2:0] C_OP_HALT = 3'b111;

  // Register control codes driven on Tx/Ty/Tz
  localparam logic [1:0] C_T_HOLD   = 2'b00;
  localparam logic [1:0] C_T_LOAD   = 2'b01;
  localparam logic [1:0] C_T_CLEAR  = 2'b10;
  localparam logic [1:0] C_T_SHIFTR = 2'b11;

  // ULA operation select
  localparam logic C_ULA_ADD = 1'b0;
  localparam logic C_ULA_SUB = 1'b1;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  // States during which the sequencer reports itself busy
  function automatic logic is_busy_state(input state_t s);
    return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) || (s == S_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_decoder
// Purpose  : Combinational opcode decode into register/ULA control codes and
//            jump/halt qualifiers for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] i_opcode,
  input  logic       i_y_zero,
  output logic [1:0] o_tx,
  output logic [1:0] o_ty,
  output logic [1:0] o_tz,
  output logic       o_tula,
  output logic       o_is_jump,
  output logic       o_take_jump,
  output logic       o_is_halt
);

  // Map each opcode to its control word; unused fields stay HOLD/ADD
  always_comb begin
    o_tx        = C_T_HOLD;
    o_ty        = C_T_HOLD;
    o_tz        = C_T_HOLD;
    o_tula      = C_ULA_ADD;
    o_is_jump   = 1'b0;
    o_take_jump = 1'b0;
    o_is_halt   = 1'b0;
    case (i_opcode)
      C_OP_LDX:  o_tx = C_T_LOAD;
      C_OP_ADD: begin
        o_ty   = C_T_LOAD;
        o_tula = C_ULA_ADD;
      end
      C_OP_SUB: begin
        o_ty   = C_T_LOAD;
        o_tula = C_ULA_SUB;
      end
      C_OP_CLR: begin
        o_tx = C_T_CLEAR;
        o_ty = C_T_CLEAR;
        o_tz = C_T_CLEAR;
      end
      C_OP_MOVZ: o_tz = C_T_LOAD;
      C_OP_SHR:  o_ty = C_T_SHIFTR;
      C_OP_JNZ: begin
        // Branch when Y is non-zero
        o_is_jump   = 1'b1;
        o_take_jump = ~i_y_zero;
      end
      C_OP_HALT: o_is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle FETCH/DECODE/EXEC sequencer driving the X/Y/Z
//            register + ULA datapath, with start/done handshake, HALT,
//            conditional jump and single-step debug mode.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W   = 3,
  parameter int OPND_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              y_zero,
  input  logic [OPND_W+2:0] instr,
  output logic [PC_W-1:0]   pc,
  output logic [OPND_W-1:0] inX,
  output logic [1:0]        Tx,
  output logic [1:0]        Ty,
  output logic [1:0]        Tz,
  output logic              Tula,
  output logic              busy,
  output logic              done
);

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [OPND_W+2:0]   r_ir;
  logic [OPND_W-1:0]   r_inx;
  logic [1:0]          r_tx;
  logic [1:0]          r_ty;
  logic [1:0]          r_tz;
  logic                r_tula;
  logic                r_busy;
  logic                r_done;

  logic [2:0]          w_opcode;
  logic [OPND_W-1:0]   w_operand;
  logic [PC_W-1:0]     w_pc_inc;
  logic [PC_W-1:0]     w_jump_target;
  logic [1:0]          w_tx;
  logic [1:0]          w_ty;
  logic [1:0]          w_tz;
  logic                w_tula;
  logic                w_is_jump;
  logic                w_take_jump;
  logic                w_is_halt;

  assign w_opcode      = r_ir[OPND_W +: 3];
  assign w_operand     = r_ir[OPND_W-1:0];
  // Wraps naturally modulo 2**PC_W
  assign w_pc_inc      = r_pc + PC_W'(1);
  // Operand bits above the program counter width are discarded
  assign w_jump_target = w_operand[PC_W-1:0];

  cpu_decoder u_decoder (
    .i_opcode    (w_opcode),
    .i_y_zero    (y_zero),
    .o_tx        (w_tx),
    .o_ty        (w_ty),
    .o_tz        (w_tz),
    .o_tula      (w_tula),
    .o_is_jump   (w_is_jump),
    .o_take_jump (w_take_jump),
    .o_is_halt   (w_is_halt)
  );

  // Sequencer FSM with registered pc, IR, operand and control outputs.
  // Control codes are loaded leaving DECODE so they are live only in EXEC;
  // the async reset drops them to HOLD immediately, aborting any write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_inx   <= '0;
      r_tx    <= C_T_HOLD;
      r_ty    <= C_T_HOLD;
      r_tz    <= C_T_HOLD;
      r_tula  <= C_ULA_ADD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_tx   <= C_T_HOLD;
      r_ty   <= C_T_HOLD;
      r_tz   <= C_T_HOLD;
      r_tula <= C_ULA_ADD;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_busy  <= is_busy_state(S_FETCH);
          end
        end
        S_FETCH: begin
          r_ir    <= instr;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_inx   <= w_operand;
          r_tx    <= w_tx;
          r_ty    <= w_ty;
          r_tz    <= w_tz;
          r_tula  <= w_tula;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_halt) begin
            r_state <= S_HALTED;
            r_busy  <= is_busy_state(S_HALTED);
            r_done  <= 1'b1;
          end else begin
            r_pc    <= (w_is_jump && w_take_jump) ? w_jump_target : w_pc_inc;
            r_state <= step_mode ? S_WAIT : S_FETCH;
          end
        end
        S_WAIT: begin
          // A step pulse and a falling step_mode both give a single advance
          if (step || !step_mode) begin
            r_state <= S_FETCH;
          end
        end
        S_HALTED: begin
          if (start) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_busy  <= is_busy_state(S_FETCH);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pc   = r_pc;
  assign inX  = r_inx;
  assign Tx   = r_tx;
  assign Ty   = r_ty;
  assign Tz   = r_tz;
  assign Tula = r_tula;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Directed self-checking bench for cpu_sequencer with a small
//            X/Y/Z datapath model and program ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  localparam int PC_W   = 3;
  localparam int OPND_W = 4;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              start     = 1'b0;
  logic              step_mode = 1'b0;
  logic              step      = 1'b0;
  logic              y_zero;
  logic [OPND_W+2:0] instr;
  logic [PC_W-1:0]   pc;
  logic [OPND_W-1:0] inX;
  logic [1:0]        Tx;
  logic [1:0]        Ty;
  logic [1:0]        Tz;
  logic              Tula;
  logic              busy;
  logic              done;

  logic [6:0] prog [8];
  logic [3:0] X      = 4'd0;
  logic [3:0] Y      = 4'd0;
  logic [3:0] Z      = 4'd0;
  logic       dp_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  cpu_sequencer #(.PC_W(PC_W), .OPND_W(OPND_W)) dut (
    .clock     (clk),
    .reset     (rst),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .y_zero    (y_zero),
    .instr     (instr),
    .pc        (pc),
    .inX       (inX),
    .Tx        (Tx),
    .Ty        (Ty),
    .Tz        (Tz),
    .Tula      (Tula),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign instr  = prog[pc];
  assign y_zero = (Y == 4'd0);

  // Datapath model: Y <= X+Y for ADD, Y <= Y-X for SUB, Z <= Y for MOVZ
  always @(posedge clk) begin
    if (dp_clr) begin
      X <= 4'd0;
      Y <= 4'd0;
      Z <= 4'd0;
    end else begin
      case (Tx)
        2'b01: X <= inX;
        2'b10: X <= 4'd0;
        2'b11: X <= X >> 1;
        default: ;
      endcase
      case (Ty)
        2'b01: Y <= Tula ? (Y - X) : (X + Y);
        2'b10: Y <= 4'd0;
        2'b11: Y <= Y >> 1;
        default: ;
      endcase
      case (Tz)
        2'b01: Z <= Y;
        2'b10: Z <= 4'd0;
        2'b11: Z <= Z >> 1;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int cnt);
    for (int i = 0; i < cnt; i++) tick();
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 8; i++) prog[i] = 7'h70;
  endtask

  task automatic load_prog_a();
    fill_halt();
    prog[0] = 7'h03;  // LDX 3
    prog[1] = 7'h10;  // ADD
    prog[2] = 7'h10;  // ADD
    prog[3] = 7'h40;  // MOVZ
    prog[4] = 7'h70;  // HALT
  endtask

  initial begin
    load_prog_a();

    // ---------------- reset state ----------------
    tickn(2);
    chk("rst_pc",   32'(pc),   0);
    chk("rst_inx",  32'(inX),  0);
    chk("rst_tx",   32'(Tx),   0);
    chk("rst_ty",   32'(Ty),   0);
    chk("rst_tz",   32'(Tz),   0);
    chk("rst_tula", 32'(Tula), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;

    // ---------------- program A: LDX 3, ADD, ADD, MOVZ, HALT ----------------
    start = 1'b1;
    tick();                          // E1: FETCH pc=0
    start = 1'b0;
    chk("a_busy_e1", 32'(busy), 1);
    chk("a_pc_e1",   32'(pc),   0);
    tickn(2);                        // E3: EXEC LDX
    chk("a_ldx_tx",  32'(Tx),  1);
    chk("a_ldx_ty",  32'(Ty),  0);
    chk("a_ldx_inx", 32'(inX), 3);
    tick();                          // E4: FETCH pc=1
    chk("a_ldx_txoff", 32'(Tx), 0);
    chk("a_pc_e4",     32'(pc), 1);
    tickn(2);                        // E6: EXEC ADD
    chk("a_add1_ty",   32'(Ty),   1);
    chk("a_add1_tula", 32'(Tula), 0);
    tickn(3);                        // E9: EXEC ADD
    chk("a_add2_ty", 32'(Ty), 1);
    chk("a_pc_e9",   32'(pc), 2);
    start = 1'b1;                    // start while busy must be ignored
    tickn(3);                        // E12: EXEC MOVZ
    start = 1'b0;
    chk("a_busy_start_pc", 32'(pc), 3);
    chk("a_movz_tz", 32'(Tz), 1);
    chk("a_movz_ty", 32'(Ty), 0);
    tickn(3);                        // E15: EXEC HALT
    chk("a_halt_pc",   32'(pc),   4);
    chk("a_halt_busy", 32'(busy), 1);
    chk("a_halt_done", 32'(done), 0);
    chk("a_halt_tx",   32'(Tx),   0);
    tick();                          // E16: HALTED
    chk("a_done",      32'(done), 1);
    chk("a_done_busy", 32'(busy), 0);
    chk("a_done_pc",   32'(pc),   4);
    chk("a_x", 32'(X), 3);
    chk("a_y", 32'(Y), 6);
    chk("a_z", 32'(Z), 6);
    tick();
    chk("a_done_pulse", 32'(done), 0);

    // ---------------- restart from HALTED ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_pc",   32'(pc),   0);
    chk("rs_busy", 32'(busy), 1);
    wait_done(60, n);
    chk("rs_latency", 32'(n), 15);
    chk("rs_y", 32'(Y), 12);
    chk("rs_z", 32'(Z), 12);

    // ---------------- reset mid-EXEC of ADD ----------------
    dp_clr = 1'b1;
    tick();
    dp_clr = 1'b0;
    start = 1'b1;
    tick();                          // E1
    start = 1'b0;
    tickn(5);                        // E6: EXEC ADD, X=3 Y=0
    chk("mr_ty_pre", 32'(Ty), 1);
    rst = 1'b1;
    #1;
    chk("mr_ty",   32'(Ty),   0);
    chk("mr_tx",   32'(Tx),   0);
    chk("mr_tz",   32'(Tz),   0);
    chk("mr_pc",   32'(pc),   0);
    chk("mr_busy", 32'(busy), 0);
    tick();
    chk("mr_y_kept", 32'(Y), 0);

    // ---------------- program B: LDX 1, CLR, SUB, JNZ 0, HALT ----------------
    fill_halt();
    prog[0] = 7'h01;
    prog[1] = 7'h30;
    prog[2] = 7'h20;
    prog[3] = 7'h60;
    prog[4] = 7'h70;
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(60, n);
    chk("b_latency", 32'(n),  15);
    chk("b_pc",      32'(pc), 4);
    chk("b_y",       32'(Y),  0);

    // ---------------- program C: LDX 1, SUB, JNZ 8 (->0), HALT ----------------
    fill_halt();
    prog[0] = 7'h01;
    prog[1] = 7'h20;
    prog[2] = 7'h68;
    prog[3] = 7'h70;
    start = 1'b1;
    tick();                          // E1
    start = 1'b0;
    tickn(8);                        // E9: EXEC JNZ, Y=15
    chk("c_y",     32'(Y),  15);
    chk("c_pc_e9", 32'(pc), 2);
    chk("c_jnz_ty", 32'(Ty), 0);
    tick();                          // E10: jump taken
    chk("c_pc_taken", 32'(pc),   0);
    chk("c_busy",     32'(busy), 1);

    // ---------------- wrap: eight LDX i, no HALT ----------------
    rst = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) prog[i] = 7'(i);
    rst = 1'b0;
    start = 1'b1;
    tick();                          // E1
    start = 1'b0;
    tickn(23);                       // E24: EXEC LDX 7
    chk("w_pc7",  32'(pc),  7);
    chk("w_inx7", 32'(inX), 7);
    chk("w_tx7",  32'(Tx),  1);
    tick();                          // E25: wrapped
    chk("w_pc0",  32'(pc),   0);
    chk("w_busy", 32'(busy), 1);
    tickn(2);                        // E27: EXEC LDX 0
    chk("w_inx0", 32'(inX), 0);
    chk("w_tx0",  32'(Tx),  1);

    // ---------------- single-step mode on program A ----------------
    rst = 1'b1;
    tick();
    load_prog_a();
    dp_clr = 1'b1;
    tick();
    dp_clr = 1'b0;
    rst = 1'b0;
    step_mode = 1'b1;
    start = 1'b1;
    tick();                          // E1
    start = 1'b0;
    tickn(3);                        // E4: WAIT after LDX
    chk("s_pc_w1",   32'(pc),   1);
    chk("s_busy_w1", 32'(busy), 1);
    tickn(3);                        // E7: still parked
    chk("s_pc_park", 32'(pc), 1);
    chk("s_ty_park", 32'(Ty), 0);
    chk("s_y_park",  32'(Y),  0);
    step = 1'b1;
    tick();                          // E8: FETCH
    step = 1'b1;                     // step during FETCH: ignored
    tick();                          // E9: DECODE
    step = 1'b0;
    tick();                          // E10: EXEC ADD
    chk("s_add_ty", 32'(Ty), 1);
    tick();                          // E11: WAIT
    chk("s_pc_w2", 32'(pc), 2);
    chk("s_y_w2",  32'(Y),  3);
    tickn(2);                        // E13: still parked
    chk("s_pc_park2", 32'(pc), 2);
    chk("s_ty_park2", 32'(Ty), 0);
    step_mode = 1'b0;
    step = 1'b1;
    tick();                          // E14: single transition to FETCH
    step = 1'b0;
    tickn(2);                        // E16: EXEC ADD
    chk("s_add2_ty", 32'(Ty), 1);
    tick();                          // E17: free-running FETCH
    chk("s_pc_free", 32'(pc), 3);
    chk("s_y_free",  32'(Y),  6);
    tickn(2);                        // E19: EXEC MOVZ
    chk("s_movz_tz", 32'(Tz), 1);
    wait_done(30, n);
    chk("s_done_lat", 32'(n),  4);
    chk("s_pc_halt",  32'(pc), 4);
    chk("s_z",        32'(Z),  6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the X/Y/Z register + ULA datapath.
- Replaces the free-running counter + fixed controller pair:
  - addresses program memory;
  - latches the instruction word;
  - drives the Tx/Ty/Tz/Tula control codes for exactly one execute cycle per instruction.
- Adds a start/done handshake, HALT, jumps and a single-step mode for debug.

Parameters:
- PC_W, 3, program counter width (program depth 2**PC_W words).
- OPND_W, 4, operand width; equals datapath width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  level-sampled; in IDLE or HALTED begins execution at pc=0.
- step_mode  in  1  1 = wait for step pulse before each fetch.
- step  in  1  single-cycle pulse advancing one instruction in step_mode.
- y_zero  in  1  datapath flag (outY == 0), used by JNZ.
- instr  in  3+OPND_W  program word {opcode[2:0], operand}, combinational read of pc.
- pc  out  PC_W  program address.
- inX  out  OPND_W  operand of latched instruction (feeds registerX).
- Tx, Ty, Tz  out  2 each  register control: 00 HOLD, 01 LOAD, 10 CLEAR, 11 SHIFTR.
- Tula  out  1  0 ADD, 1 SUB.
- busy  out  1  high in FETCH/DECODE/EXEC/WAIT.
- done  out  1  one-cycle pulse on entry to HALTED.

Behaviour:
- Reset values: state=IDLE, pc=0, IR=0, inX=0, Tx=Ty=Tz=HOLD, Tula=0, busy=0, done=0.
- States and transitions:
  - IDLE: start=1 -> FETCH (pc=0).
  - FETCH: pc stable; instr captured into IR at the edge leaving FETCH -> DECODE.
  - DECODE: inX<=operand; -> EXEC.
  - EXEC: control codes valid this cycle only; datapath registers capture at the closing edge.
  - After EXEC: -> WAIT if step_mode=1, else -> FETCH.
  - WAIT: step=1 -> FETCH; step_mode dropping to 0 also -> FETCH.
  - HALTED: done pulses first cycle; start=1 -> FETCH with pc=0.
- Outputs outside EXEC: all T codes HOLD; Tula holds 0.
- Latency: 3 cycles per instruction, free-running.
- Opcodes (control in EXEC; pc update at end of EXEC):
  - 000 LDX: Tx=LOAD; pc+1.
  - 001 ADD: Ty=LOAD, Tula=0 (Y<=X+Y); pc+1.
  - 010 SUB: Ty=LOAD, Tula=1; pc+1.
  - 011 CLR: Tx=Ty=Tz=CLEAR; pc+1.
  - 100 MOVZ: Tz=LOAD (Z<=Y); pc+1.
  - 101 SHR: Ty=SHIFTR; pc+1.
  - 110 JNZ: no register control; pc<=operand[PC_W-1:0] if y_zero=0, else pc+1.
  - 111 HALT: no control; pc unchanged; -> HALTED.
- Boundary conditions:
  - pc arithmetic is modulo 2**PC_W (7+1 -> 0 for PC_W=3); no halt on wrap.
  - Operand bits above PC_W are ignored by JNZ.
  - start while busy: ignored.
  - step outside WAIT: ignored.
  - step and step_mode falling in the same cycle: single transition to FETCH.
  - y_zero sampled only in EXEC of JNZ. It reflects Y before that edge, so JNZ placed immediately after ADD/SUB sees the updated Y.
  - Reset at any state, including mid-EXEC: immediate return to reset values; T codes forced HOLD asynchronously so no partial write occurs.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode constants;
  - T-code constants (HOLD/LOAD/CLEAR/SHIFTR);
  - ULA op constants;
  - state encoding.
- Sub-module cpu_decoder: combinational {opcode, y_zero} -> {Tx, Ty, Tz, Tula, is_jump, take_jump, is_halt}.
- cpu_sequencer: FSM, pc, IR and output gating only.

Test Plan:
- Reset mid-EXEC of ADD -> all T=HOLD within same cycle, pc=0, busy=0; no Y change on next edge.
- Program {LDX 3, ADD, ADD, MOVZ, HALT}, start=1 -> done after 15 cycles; EXEC cycles show Tx=01, Ty=01/Tula=0 twice, Tz=01; pc=4 at halt.
- Program {LDX 1, CLR, SUB, JNZ 0, HALT} with y_zero driven from model -> JNZ not taken when Y=0; taken (pc=0) when Y=15.
- Program with no HALT at depth 8 -> pc wraps 7->0, execution continues, busy stays 1.
- step_mode=1 -> sequencer parks in WAIT after each EXEC; each step pulse yields exactly one EXEC; step in FETCH ignored.
- start asserted while busy and again in HALTED -> first ignored; second restarts at pc=0 with a new done pulse on next HALT.
